// File: rtl/npu_addertree_pkg.sv
// Shared definitions for the pipelined adder tree.
// Holds the default widths and the helper functions that size the tree:
//   clog2   - ceiling log2, gives the number of tree levels
//   lvl_w   - operand width entering a given level (one bit of growth per level)
//   lvl_cnt - operand count entering a given level (ceil(n / 2^lvl))
package npu_addertree_pkg;

    localparam int unsigned DefNIn  = 9;
    localparam int unsigned DefInW  = 16;
    localparam int unsigned DefOutW = 24;
    localparam int unsigned DefAccW = 32;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned lvl_w(input int unsigned in_w, input int unsigned lvl);
        return in_w + lvl;
    endfunction

    function automatic int unsigned lvl_cnt(input int unsigned n, input int unsigned lvl);
        return (n + (32'd1 << lvl) - 1) >> lvl;
    endfunction

endpackage

// File: rtl/addertree_level.sv
// One registered pairwise reduction level of the adder tree.
// Adds operand pairs (2k, 2k+1); an odd trailing operand is sign-extended and passed on.
// Ports:
//   clk_i, reset_i  - clock, synchronous active-high reset
//   stall_i         - freeze all registers of this level
//   valid_i/mode_i/last_i/data_i - incoming beat (Count operands of Width bits)
//   valid_o/mode_o/last_o/data_o - registered beat ((Count+1)/2 operands of Width+1 bits)
module addertree_level #(
    parameter int unsigned Count = 2,
    parameter int unsigned Width = 16,
    localparam int unsigned OutCount = (Count + 1) / 2,
    localparam int unsigned OutW     = Width + 1
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     stall_i,
    input  logic                     valid_i,
    input  logic                     mode_i,
    input  logic                     last_i,
    input  logic [Count*Width-1:0]   data_i,
    output logic                     valid_o,
    output logic                     mode_o,
    output logic                     last_o,
    output logic [OutCount*OutW-1:0] data_o
);

    logic [OutCount*OutW-1:0] sum_d, data_q;
    logic                     valid_q, mode_q, last_q;

    // Operands are sign-extended by one bit before adding, so the unsigned add in
    // OutW bits is the exact signed sum.
    for (genvar k = 0; k < OutCount; k++) begin : g_pair
        logic [Width-1:0] op_a;
        assign op_a = data_i[2*k*Width +: Width];
        if (2*k + 1 < Count) begin : g_add
            logic [Width-1:0] op_b;
            assign op_b = data_i[(2*k+1)*Width +: Width];
            assign sum_d[k*OutW +: OutW] = {op_a[Width-1], op_a} + {op_b[Width-1], op_b};
        end else begin : g_pass
            assign sum_d[k*OutW +: OutW] = {op_a[Width-1], op_a};
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            valid_q <= 1'b0;
            mode_q  <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else if (!stall_i) begin
            valid_q <= valid_i;
            mode_q  <= mode_i;
            last_q  <= last_i;
            data_q  <= sum_d;
        end
    end

    assign valid_o = valid_q;
    assign mode_o  = mode_q;
    assign last_o  = last_q;
    assign data_o  = data_q;

endmodule

// File: rtl/addertree_pipe.sv
// Pipelined signed adder tree with a group accumulator and valid/ready handshake.
// N_IN operands per beat are reduced in clog2(N_IN) registered levels, then an
// accumulator stage either emits each beat (acc_mode=0) or sums beats up to in_last.
// Any out_valid && !out_ready freezes the whole pipeline.
// Build option: define ADDERTREE_SAT_EN to clamp out-of-range results; otherwise
// out_data wraps to the low OUT_W bits. out_ovf is reported in both builds.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   in_valid/in_ready            - input handshake
//   in_data                      - packed operands, operand k at [k*IN_W +: IN_W]
//   in_last, acc_mode            - group end marker, accumulate enable (travel with beat)
//   out_valid/out_ready          - output handshake
//   out_data, out_ovf            - signed result, out-of-range flag
module addertree_pipe
    import npu_addertree_pkg::*;
#(
    parameter int unsigned N_IN  = DefNIn,
    parameter int unsigned IN_W  = DefInW,
    parameter int unsigned OUT_W = DefOutW,
    parameter int unsigned ACC_W = DefAccW   // must be >= IN_W + clog2(N_IN)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N_IN*IN_W-1:0] in_data,
    input  logic                 in_last,
    input  logic                 acc_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_W-1:0]     out_data,
    output logic                 out_ovf
);

    localparam int unsigned L     = clog2(N_IN);
    localparam int unsigned TreeW = lvl_w(IN_W, L);
    localparam int unsigned BusW  = N_IN * TreeW;

    localparam logic signed [ACC_W-1:0] OutMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] OutMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic stall;

    // Level i output lives in the low bits of st_data[i+1]; the rest is zero padding.
    logic [BusW-1:0] st_data  [L+1];
    logic            st_valid [L+1];
    logic            st_mode  [L+1];
    logic            st_last  [L+1];

    assign stall    = out_valid && !out_ready;
    assign in_ready = !stall;

    assign st_data[0]  = BusW'(in_data);
    assign st_valid[0] = in_valid;
    assign st_mode[0]  = acc_mode;
    assign st_last[0]  = in_last;

    for (genvar i = 0; i < L; i++) begin : g_lvl
        localparam int unsigned Cnt  = lvl_cnt(N_IN, i);
        localparam int unsigned W    = lvl_w(IN_W, i);
        localparam int unsigned OCnt = lvl_cnt(N_IN, i + 1);

        logic [OCnt*(W+1)-1:0] lvl_data;

        addertree_level #(
            .Count (Cnt),
            .Width (W)
        ) u_level (
            .clk_i   (clk),
            .reset_i (reset),
            .stall_i (stall),
            .valid_i (st_valid[i]),
            .mode_i  (st_mode[i]),
            .last_i  (st_last[i]),
            .data_i  (st_data[i][Cnt*W-1:0]),
            .valid_o (st_valid[i+1]),
            .mode_o  (st_mode[i+1]),
            .last_o  (st_last[i+1]),
            .data_o  (lvl_data)
        );

        assign st_data[i+1] = BusW'(lvl_data);

        if (Cnt * W < BusW) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^st_data[i][BusW-1:Cnt*W];
        end
    end

    logic unused_tree_pad;
    assign unused_tree_pad = ^st_data[L][BusW-1:TreeW];

    // Accumulator / output stage
    logic signed [ACC_W-1:0] tree_sum, total, acc_d, acc_q;
    logic                    emit, ovf_now;
    logic                    out_valid_d, out_valid_q, out_ovf_d, out_ovf_q;
    logic [OUT_W-1:0]        out_data_d, out_data_q;

    assign tree_sum = ACC_W'($signed(st_data[L][TreeW-1:0]));

    always_comb begin
        // acc is zero whenever no group is open, so a mode-0 beat simply replaces it,
        // and a mode-0 beat arriving mid-group folds the open partial sum in.
        total       = acc_q + tree_sum;
        emit        = st_valid[L] && (!st_mode[L] || st_last[L]);
        ovf_now     = (total > OutMax) || (total < OutMin);
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ovf_d   = out_ovf_q;
        if (!stall) begin
            out_valid_d = emit;
            if (st_valid[L]) acc_d = emit ? '0 : total;
            if (emit) begin
                out_ovf_d = ovf_now;
`ifdef ADDERTREE_SAT_EN
                if (ovf_now) begin
                    out_data_d = total[ACC_W-1] ? OutMin[OUT_W-1:0] : OutMax[OUT_W-1:0];
                end else begin
                    out_data_d = total[OUT_W-1:0];
                end
`else
                out_data_d = total[OUT_W-1:0];
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_addertree_pipe.sv
// Self-checking bench for addertree_pipe: directed cases plus a randomized run
// against a behavioural sum/accumulate model.
module tb_addertree_pipe;

    localparam int NI = 9;
    localparam int IW = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset = 1'b1;
    logic             in_valid = 1'b0, in_ready, in_last = 1'b0, acc_mode = 1'b0;
    logic [NI*IW-1:0] in_data = '0;
    logic             out_valid, out_ready = 1'b1, out_ovf;
    logic [23:0]      out_data;

    addertree_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .acc_mode  (acc_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    // Odd-width tree instance
    logic          d5_in_valid = 1'b0, d5_in_ready, d5_out_valid, d5_out_ovf;
    logic [5*16-1:0] d5_in_data = '0;
    logic [23:0]   d5_out_data;

    addertree_pipe #(
        .N_IN  (5),
        .IN_W  (16),
        .OUT_W (24),
        .ACC_W (32)
    ) u_dut5 (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (d5_in_valid),
        .in_ready  (d5_in_ready),
        .in_data   (d5_in_data),
        .in_last   (1'b1),
        .acc_mode  (1'b0),
        .out_valid (d5_out_valid),
        .out_ready (1'b1),
        .out_data  (d5_out_data),
        .out_ovf   (d5_out_ovf)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [23:0] data;
        logic        ovf;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    longint      partial = 0;
    int          cyc = 0;
    int          n_out = 0;
    int          inr_low = 0;
    logic        chk_lat = 1'b0;
    logic        took = 1'b0;
    logic        stalled_prev = 1'b0;
    logic [23:0] prev_data = '0, last_data = '0;
    logic        prev_ovf = 1'b0, last_ovf = 1'b0;

    function automatic longint beat_sum(input logic [NI*IW-1:0] d);
        longint s;
        logic signed [IW-1:0] op;
        s = 0;
        for (int k = 0; k < NI; k++) begin
            op = d[k*IW +: IW];
            s += longint'(op);
        end
        return s;
    endfunction

    function automatic exp_t mk_exp(input longint total, input int c);
        exp_t e;
        e.ovf = (total > 8388607) || (total < -8388608);
        e.cyc = c;
`ifdef ADDERTREE_SAT_EN
        if (e.ovf) e.data = (total > 0) ? 24'h7FFFFF : 24'h800000;
        else e.data = total[23:0];
`else
        e.data = total[23:0];
`endif
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        took = 1'b0;
        if (reset) begin
            exp_q.delete();
            partial      = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev) begin
                check("stall_hold_valid", 64'(out_valid), 64'd1);
                check("stall_hold_data", 64'(out_data), 64'(prev_data));
                check("stall_hold_ovf", 64'(out_ovf), 64'(prev_ovf));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(out_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("out_data", 64'(out_data), 64'(e.data));
                    check("out_ovf", 64'(out_ovf), 64'(e.ovf));
                    if (chk_lat) check("latency", 64'(cyc - e.cyc), 64'd5);
                    last_data = out_data;
                    last_ovf  = out_ovf;
                    n_out++;
                end
            end
            stalled_prev = out_valid && !out_ready;
            prev_data    = out_data;
            prev_ovf     = out_ovf;
            if (!in_ready) inr_low++;
            if (in_valid && in_ready) begin
                took = 1'b1;
                partial += beat_sum(in_data);
                if (!acc_mode || in_last) begin
                    exp_q.push_back(mk_exp(partial, cyc));
                    partial = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [NI*IW-1:0] rep(input logic [IW-1:0] v);
        logic [NI*IW-1:0] r;
        for (int k = 0; k < NI; k++) r[k*IW +: IW] = v;
        return r;
    endfunction

    function automatic logic [NI*IW-1:0] rnd_data();
        logic [NI*IW-1:0] r;
        case ($urandom_range(0, 5))
            0: r = rep(16'h7FFF);
            1: r = rep(16'h8000);
            default: for (int k = 0; k < NI; k++) r[k*IW +: IW] = 16'($urandom);
        endcase
        return r;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the beat has been taken.
    task automatic drive_beat(input logic [NI*IW-1:0] d, input logic m, input logic l);
        in_valid = 1'b1;
        in_data  = d;
        acc_mode = m;
        in_last  = l;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        check("accept_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && exp_q.size() != 0; t++) @(negedge clk);
        repeat (3) @(negedge clk);
        check("drain", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    int n0, i0, grp, lat5;

    initial begin
        grp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_ovf", 64'(out_ovf), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single beat, all ones
        chk_lat = 1'b1;
        n0 = n_out;
        drive_beat(rep(16'd1), 1'b0, 1'b0);
        in_valid = 1'b0;
        wait_drain();
        check("single_count", 64'(n_out - n0), 64'd1);
        check("single_data", 64'(last_data), 64'd9);
        check("single_ovf", 64'(last_ovf), 64'd0);

        // Group of 3 beats of -32768
        n0 = n_out;
        drive_beat(rep(16'h8000), 1'b1, 1'b0);
        drive_beat(rep(16'h8000), 1'b1, 1'b0);
        drive_beat(rep(16'h8000), 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();
        check("group_count", 64'(n_out - n0), 64'd1);
        check("group_data", 64'(last_data), 64'(24'hF28000));  // -884736
        check("group_ovf", 64'(last_ovf), 64'd0);

        // Back-pressure: 8 beats streaming, out_ready low for 10 cycles
        chk_lat = 1'b0;
        n0 = n_out;
        i0 = inr_low;
        fork
            begin
                for (int b = 0; b < 8; b++) drive_beat(rnd_data(), 1'b0, 1'b1);
                in_valid = 1'b0;
            end
            begin
                repeat (3) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        wait_drain();
        check("bp_count", 64'(n_out - n0), 64'd8);
        check("bp_in_ready_dropped", 64'(inr_low > i0), 64'd1);

        // Overflow: 40 beats of 32767 accumulated, back to back
        chk_lat = 1'b1;
        n0 = n_out;
        i0 = inr_low;
        for (int b = 0; b < 40; b++) drive_beat(rep(16'h7FFF), 1'b1, b == 39);
        in_valid = 1'b0;
        wait_drain();
        check("ovf_count", 64'(n_out - n0), 64'd1);
        check("ovf_flag", 64'(last_ovf), 64'd1);
`ifdef ADDERTREE_SAT_EN
        check("ovf_data", 64'(last_data), 64'(24'h7FFFFF));
`else
        check("ovf_data", 64'(last_data), 64'(24'hB3FE98));  // 11796120 mod 2^24
`endif
        check("ovf_no_bubble", 64'(inr_low - i0), 64'd0);

        // Reset between beats 2 and 3 of a group
        drive_beat(rep(16'd100), 1'b1, 1'b0);
        drive_beat(rep(16'd100), 1'b1, 1'b0);
        in_valid = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n0 = n_out;
        drive_beat(rep(16'd1), 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();
        check("rst_grp_count", 64'(n_out - n0), 64'd1);
        check("rst_grp_data", 64'(last_data), 64'd9);

        // Odd tree: N_IN=5, operands {1,2,3,4,-100}
        d5_in_data  = {16'hFF9C, 16'd4, 16'd3, 16'd2, 16'd1};
        d5_in_valid = 1'b1;
        @(posedge clk);
        #1 d5_in_valid = 1'b0;
        lat5 = 0;
        for (int t = 1; t <= 12 && lat5 == 0; t++) begin
            @(negedge clk);
            if (d5_out_valid) lat5 = t;
        end
        check("odd_latency", 64'(lat5), 64'd4);
        check("odd_data", 64'(d5_out_data), 64'(24'hFFFFA6));  // -90
        check("odd_ovf", 64'(d5_out_ovf), 64'd0);
        @(posedge clk);
        #1;

        // Randomized traffic with random back-pressure
        chk_lat = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!in_valid || took) begin
                in_valid = ($urandom_range(0, 3) != 0);
                if (in_valid) begin
                    in_data  = rnd_data();
                    acc_mode = ($urandom_range(0, 3) != 0);
                    in_last  = ($urandom_range(0, 7) == 0) || (grp >= 39);
                    if (acc_mode && !in_last) grp++;
                    else grp = 0;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk);
            #1;
        end
        // Close any open group so every accepted beat yields an output
        if (in_valid && !took) drive_beat(in_data, acc_mode, in_last);
        out_ready = 1'b1;
        drive_beat(rnd_data(), 1'b1, 1'b1);
        in_valid = 1'b0;
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
